avalon_packet_buffer: RTL and testbench
=======================================

// Module: avalon_packet_buffer
// PURPOSE
//  Store-and-forward packet FIFO directly downstream of the avalon_enforced protocol stage.
//  Accepts whole, protocol-clean Avalon-ST messages and releases a message only once its eop beat is stored.
//  Drops any message that does not fit in the buffer, so the consumer never receives a partial packet.
// PARAMETERS
//  DATA_WIDTH   8   data bus width, bits
//  EMPTY_WIDTH  1   width of the empty field (>=1)
//  DEPTH        16  buffer entries (beats), power of two, >=4
// PORTS
//  clk            in   1                    system clock
//  rst            in   1                    asynchronous, active-low reset
//  enforced_msg   avalon_st_if.slave  -     input stream (valid/ready/sop/eop/data/empty)
//  buffered_msg   avalon_st_if.master -     output stream
//  drop_pulse     out  1                    one-cycle pulse: the current input message is being dropped
//  packet_count   out  $clog2(DEPTH)+1      complete messages currently held
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. Reset is port rst, clock is clk.
//  - Reset values:
//    - all pointers 0; state WAIT_FOR_SOP
//    - buffered_msg.valid/sop/eop/data/empty = 0
//    - drop_pulse = 0; packet_count = 0
//    - enforced_msg.ready = 1
//  - Reset mid-operation discards all stored and partial messages.
//  - Storage: DEPTH entries of {sop, eop, empty, data}.
//    - Pointers wr_ptr, commit_ptr, rd_ptr, each ADDR_W+1 bits (ADDR_W = $clog2(DEPTH)); the MSB distinguishes full from empty.
//    - free = DEPTH - (wr_ptr - rd_ptr), computed from registered pointers.
//    - A read in the same cycle does not create space for that cycle's write.
//  - Input side: enforced_msg.ready is held at 1. The block never back-pressures; overflow is handled by dropping.
//    A beat is accepted when valid=1.
//  - Input state machine:
//    - WAIT_FOR_SOP:
//      - Accepted beat with sop=0 is ignored (upstream guarantees this does not occur).
//      - sop=1 with free>0: write the beat, wr_ptr++.
//        - If eop=1 as well: commit, stay in WAIT_FOR_SOP.
//        - Otherwise go to WRITE.
//      - sop=1 with free=0: drop_pulse=1; go to DROP (or stay in WAIT_FOR_SOP if eop=1).
//    - WRITE:
//      - Beat with free>0 and sop=0: write, wr_ptr++. If eop=1: commit, go to WAIT_FOR_SOP.
//      - Beat with free=0: wr_ptr <= commit_ptr (rollback); drop_pulse=1; go to DROP, or WAIT_FOR_SOP if eop=1.
//      - Beat with sop=1 (defensive): roll back, drop_pulse=1, then treat the beat as a new sop from WAIT_FOR_SOP in the same cycle.
//    - DROP: discard beats; return to WAIT_FOR_SOP on eop=1; a beat with sop=1 restarts as in WRITE.
//  - A message longer than DEPTH beats is always dropped.
//  - Commit on a written eop beat: commit_ptr <= wr_ptr+1; packet_count++.
//  - Output side:
//    - buffered_msg.valid=1 whenever rd_ptr != commit_ptr.
//    - Fields are driven from entry rd_ptr (register-array read, no extra latency).
//    - A beat transfers on valid & ready; then rd_ptr++.
//    - While valid=1 and ready=0, every output field is held stable.
//    - Output empty is forced to 0 on beats with eop=0.
//    - The buffered_msg.ready input is only sampled.
//  - Latency: the first beat of a message is valid one cycle after its eop beat is accepted (commit_ptr registered).
//    Back-to-back beats then stream at 1 beat/cycle.
//  - packet_count:
//    - +1 on commit; -1 on a transferred eop beat; unchanged if both happen in the same cycle.
//    - Never exceeds DEPTH (one beat per message minimum).
//  - Pointer arithmetic wraps modulo 2*DEPTH. The full and empty conditions are exact at the wrap.
//  - drop_pulse is registered: high for exactly the cycle after the dropping beat, once per dropped message.
// STRUCTURE
//  - Package avalon_packet_buffer_pack:
//    - typedef enum {WAIT_FOR_SOP, WRITE, DROP} avalon_packet_buffer_sm_t
//    - typedef struct packed entry type {sop, eop, empty, data}, width-parameterised via localparams in the module
//  - Sub-module avalon_buffer_ram: DEPTH x entry register array, one write port (clk), one asynchronous read port.
//    No reset on contents.
//  - Top module holds pointers, state machine, counters and output muxing.
// TESTING (DEPTH=8, DATA_WIDTH=8)
//  1. 3-beat msg 0x11,0x22,0x33 (empty=0), out ready=1.
//     -> valid rises 1 cycle after the eop beat; same data/sop/eop out; packet_count 1->0.
//  2. Single-beat msg sop=eop=1, data=0xA5, empty=1.
//     -> one out beat with sop=eop=1, empty=1; no drop_pulse.
//  3. Out ready=0; msgs of 4, 3, then 2 beats.
//     -> first two stored (count=2); the third overflows, giving drop_pulse once.
//     -> After ready=1, exactly 7 beats are output.
//  4. 10-beat msg into an empty buffer.
//     -> drop_pulse once; nothing is output; a following 2-beat msg passes intact.
//  5. Steady 1-beat msgs every cycle with ready=1 for 40 cycles.
//     -> pointers wrap; all 40 are output in order; count never exceeds 2; no drops.
//  6. Assert rst mid-msg (2 of 4 beats in, 1 committed msg held).
//     -> valid=0 and count=0 immediately; after release, a new msg passes unaffected.

Source files
------------

// File: rtl/avalon_packet_buffer_pkg.sv
// avalon_packet_buffer_pack: shared types and default sizes for the packet buffer
package avalon_packet_buffer_pack;
   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_EMPTY_WIDTH = 1;
   localparam int DEF_DEPTH       = 16;
   typedef enum logic [1:0] {WAIT_FOR_SOP, WRITE, DROP} avalon_packet_buffer_sm_t;
endpackage

// File: rtl/avalon_packet_buffer_if.sv
// avalon_st_if: Avalon-ST stream bundle with source (master) and sink (slave) views
interface avalon_st_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int EMPTY_WIDTH = 1
) ();
   logic                   valid;
   logic                   ready;
   logic                   sop;
   logic                   eop;
   logic [DATA_WIDTH-1:0]  data;
   logic [EMPTY_WIDTH-1:0] empty;
   modport master (output valid, sop, eop, data, empty, input ready);
   modport slave  (input valid, sop, eop, data, empty, output ready);
endinterface

// File: rtl/avalon_packet_buffer_ram.sv
// avalon_buffer_ram: DEPTH x WIDTH register array, one clocked write port, one asynchronous read port
module avalon_buffer_ram #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   // contents are not reset; validity is tracked by the pointers in the top
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/avalon_packet_buffer.sv
// avalon_packet_buffer: store-and-forward Avalon-ST FIFO that drops messages which do not fit
module avalon_packet_buffer
   import avalon_packet_buffer_pack::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int EMPTY_WIDTH = DEF_EMPTY_WIDTH,
   parameter int DEPTH       = DEF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   avalon_st_if.slave             enforced_msg,
   avalon_st_if.master            buffered_msg,
   output logic                   drop_pulse,
   output logic [$clog2(DEPTH):0] packet_count
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PW = ADDR_W + 1;
   localparam logic [PW-1:0] FULL = PW'(DEPTH);
   typedef struct packed {
      logic                   sop;
      logic                   eop;
      logic [EMPTY_WIDTH-1:0] empty;
      logic [DATA_WIDTH-1:0]  data;
   } entry_t;
   avalon_packet_buffer_sm_t state_q;
   logic [PW-1:0] wr_q, commit_q, rd_q, count_q;
   logic [PW-1:0] wr_d, commit_d, rd_d, count_d, base;
   logic drop_q, drop_d;
   logic restart, start, cont, space, we, commit, out_valid, xfer;
   entry_t wr_e, rd_e;
   assign wr_e = {enforced_msg.sop, enforced_msg.eop, enforced_msg.empty, enforced_msg.data};
   // a sop outside WAIT_FOR_SOP abandons the partial message, so it writes from the last commit point
   always_comb begin
      start     = enforced_msg.valid && enforced_msg.sop;
      restart   = start && state_q != WAIT_FOR_SOP;
      cont      = enforced_msg.valid && !enforced_msg.sop && state_q == WRITE;
      base      = restart ? commit_q : wr_q;
      space     = (base - rd_q) != FULL;
      we        = (start || cont) && space;
      commit    = we && enforced_msg.eop;
      out_valid = rd_q != commit_q;
      xfer      = out_valid && buffered_msg.ready;
      wr_d      = we ? base + PW'(1) : (enforced_msg.valid && state_q != WAIT_FOR_SOP) ? commit_q : wr_q;
      commit_d  = commit ? base + PW'(1) : commit_q;
      rd_d      = xfer ? rd_q + PW'(1) : rd_q;
      count_d   = count_q + PW'(commit) - PW'(xfer && rd_e.eop);
      drop_d    = enforced_msg.valid && ((enforced_msg.sop && !space) ||
                  (state_q == WRITE && (enforced_msg.sop || !space)));
   end
   // input state machine, pointers, message counter and registered drop pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= WAIT_FOR_SOP;
         wr_q     <= '0;
         commit_q <= '0;
         rd_q     <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
      end else begin
         wr_q     <= wr_d;
         commit_q <= commit_d;
         rd_q     <= rd_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
         if (start || (enforced_msg.valid && state_q != WAIT_FOR_SOP))
            state_q <= enforced_msg.eop ? WAIT_FOR_SOP :
                       (space && (start || state_q == WRITE)) ? WRITE : DROP;
      end
   end
   avalon_buffer_ram #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (base[ADDR_W-1:0]),
      .wdata_i (wr_e),
      .raddr_i (rd_q[ADDR_W-1:0]),
      .rdata_o (rd_e)
   );
   assign enforced_msg.ready = 1'b1;
   assign buffered_msg.valid = out_valid;
   assign buffered_msg.sop   = out_valid && rd_e.sop;
   assign buffered_msg.eop   = out_valid && rd_e.eop;
   assign buffered_msg.data  = out_valid ? rd_e.data : '0;
   assign buffered_msg.empty = (out_valid && rd_e.eop) ? rd_e.empty : '0;
   assign drop_pulse   = drop_q;
   assign packet_count = count_q;
endmodule

// File: tb/tb_avalon_packet_buffer.sv
// tb_avalon_packet_buffer: directed self-checking bench for the store-and-forward packet buffer
module tb_avalon_packet_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic drop;
   logic [3:0] cnt;
   int passed = 0;
   int total = 0;
   int n, nd, nv, maxc;
   logic [7:0] exp3 [7];
   always #5 clk = ~clk;
   avalon_st_if #(.DATA_WIDTH(8), .EMPTY_WIDTH(1)) in_if ();
   avalon_st_if #(.DATA_WIDTH(8), .EMPTY_WIDTH(1)) out_if ();
   avalon_packet_buffer #(.DATA_WIDTH(8), .EMPTY_WIDTH(1), .DEPTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .enforced_msg (in_if),
      .buffered_msg (out_if),
      .drop_pulse   (drop),
      .packet_count (cnt)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic beat(input logic s, input logic e, input logic [7:0] d, input logic em);
      in_if.valid = 1'b1;
      in_if.sop   = s;
      in_if.eop   = e;
      in_if.data  = d;
      in_if.empty = em;
      step();
      in_if.valid = 1'b0;
      in_if.sop   = 1'b0;
      in_if.eop   = 1'b0;
   endtask
   initial begin
      in_if.valid = 0; in_if.sop = 0; in_if.eop = 0; in_if.data = 0; in_if.empty = 0;
      out_if.ready = 1'b1;
      exp3 = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h50, 8'h51, 8'h52};
      #2 rst = 1'b0;
      #10;
      chk("rst_valid", out_if.valid, 0);
      chk("rst_sop", out_if.sop, 0);
      chk("rst_eop", out_if.eop, 0);
      chk("rst_data", out_if.data, 0);
      chk("rst_empty", out_if.empty, 0);
      chk("rst_drop", drop, 0);
      chk("rst_count", cnt, 0);
      chk("rst_in_ready", in_if.ready, 1);
      @(negedge clk) rst = 1'b1;
      step();
      // 1: three-beat message
      beat(1, 0, 8'h11, 0);
      chk("t1_valid_b0", out_if.valid, 0);
      beat(0, 0, 8'h22, 0);
      chk("t1_valid_b1", out_if.valid, 0);
      beat(0, 1, 8'h33, 0);
      chk("t1_valid", out_if.valid, 1);
      chk("t1_d0", out_if.data, 8'h11);
      chk("t1_sop0", out_if.sop, 1);
      chk("t1_cnt1", cnt, 1);
      step();
      chk("t1_d1", out_if.data, 8'h22);
      chk("t1_sop1", out_if.sop, 0);
      step();
      chk("t1_d2", out_if.data, 8'h33);
      chk("t1_eop2", out_if.eop, 1);
      chk("t1_cnt_last", cnt, 1);
      step();
      chk("t1_valid_end", out_if.valid, 0);
      chk("t1_cnt0", cnt, 0);
      // 2: single-beat message with empty=1
      beat(1, 1, 8'hA5, 1);
      chk("t2_valid", out_if.valid, 1);
      chk("t2_sop", out_if.sop, 1);
      chk("t2_eop", out_if.eop, 1);
      chk("t2_empty", out_if.empty, 1);
      chk("t2_data", out_if.data, 8'hA5);
      chk("t2_drop", drop, 0);
      step();
      chk("t2_valid_end", out_if.valid, 0);
      chk("t2_drop_end", drop, 0);
      // 3: overflow while output stalled
      out_if.ready = 1'b0;
      beat(1, 0, 8'h40, 0); beat(0, 0, 8'h41, 0); beat(0, 0, 8'h42, 0); beat(0, 1, 8'h43, 0);
      beat(1, 0, 8'h50, 0); beat(0, 0, 8'h51, 0); beat(0, 1, 8'h52, 0);
      chk("t3_cnt2", cnt, 2);
      chk("t3_valid", out_if.valid, 1);
      beat(1, 0, 8'h60, 0);
      chk("t3_drop_pre", drop, 0);
      beat(0, 1, 8'h61, 0);
      chk("t3_drop", drop, 1);
      step();
      chk("t3_drop_once", drop, 0);
      chk("t3_cnt_after_drop", cnt, 2);
      chk("t3_hold_data", out_if.data, 8'h40);
      chk("t3_hold_sop", out_if.sop, 1);
      out_if.ready = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_if.valid) begin
            if (n < 7) chk("t3_data", out_if.data, exp3[n]);
            n++;
         end
         step();
      end
      chk("t3_nbeats", n, 7);
      chk("t3_cnt0", cnt, 0);
      // 4: ten-beat message never fits
      nd = 0; nv = 0;
      for (int i = 0; i < 12; i++) begin
         in_if.valid = i < 10;
         in_if.sop   = i == 0;
         in_if.eop   = i == 9;
         in_if.data  = 8'hB0 + 8'(i);
         step();
         if (drop) nd++;
         if (out_if.valid) nv++;
      end
      in_if.valid = 0; in_if.sop = 0; in_if.eop = 0;
      chk("t4_drops", nd, 1);
      chk("t4_no_output", nv, 0);
      chk("t4_cnt", cnt, 0);
      beat(1, 0, 8'h70, 1);
      beat(0, 1, 8'h71, 1);
      chk("t4_valid", out_if.valid, 1);
      chk("t4_d0", out_if.data, 8'h70);
      chk("t4_sop0", out_if.sop, 1);
      chk("t4_empty_forced0", out_if.empty, 0);
      step();
      chk("t4_d1", out_if.data, 8'h71);
      chk("t4_eop1", out_if.eop, 1);
      chk("t4_empty1", out_if.empty, 1);
      step();
      chk("t4_valid_end", out_if.valid, 0);
      // 5: forty back-to-back single-beat messages
      n = 0; nd = 0; maxc = 0;
      for (int i = 0; i < 42; i++) begin
         in_if.valid = i < 40;
         in_if.sop   = 1'b1;
         in_if.eop   = 1'b1;
         in_if.empty = 1'b0;
         in_if.data  = 8'h80 + 8'(i);
         step();
         if (out_if.valid) begin
            chk("t5_data", out_if.data, 8'h80 + n);
            n++;
         end
         if (int'(cnt) > maxc) maxc = int'(cnt);
         if (drop) nd++;
      end
      in_if.valid = 0; in_if.sop = 0; in_if.eop = 0;
      chk("t5_nout", n, 40);
      chk("t5_maxcnt", maxc, 1);
      chk("t5_drops", nd, 0);
      // 6: reset mid-message
      out_if.ready = 1'b0;
      beat(1, 1, 8'h90, 0);
      beat(1, 0, 8'hC0, 0);
      beat(0, 0, 8'hC1, 0);
      chk("t6_cnt_pre", cnt, 1);
      chk("t6_valid_pre", out_if.valid, 1);
      #2 rst = 1'b0;
      #1;
      chk("t6_valid_rst", out_if.valid, 0);
      chk("t6_cnt_rst", cnt, 0);
      chk("t6_data_rst", out_if.data, 0);
      @(negedge clk) rst = 1'b1;
      out_if.ready = 1'b1;
      step();
      chk("t6_valid_idle", out_if.valid, 0);
      beat(1, 0, 8'hD1, 0);
      beat(0, 1, 8'hD2, 0);
      chk("t6_valid", out_if.valid, 1);
      chk("t6_d0", out_if.data, 8'hD1);
      chk("t6_sop0", out_if.sop, 1);
      step();
      chk("t6_d1", out_if.data, 8'hD2);
      chk("t6_eop1", out_if.eop, 1);
      step();
      chk("t6_valid_end", out_if.valid, 0);
      chk("t6_cnt_end", cnt, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
